cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter C_WIDTH, default `WAY, number of completion slots granted per cycle.
REQ-002 Parameter E_WIDTH, default `NUM_FU_TYPE * `WAY, number of execute-result requesters.
REQ-003 Localparam PTR_LEN = `CAL_IDX_LEN(E_WIDTH), width of the round-robin pointer.
REQ-004 clock  input  1  system clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  pipeline flush; discards in-flight grants.
REQ-007 hold  input  1  downstream back-pressure; completion consumers cannot accept this cycle.
REQ-008 execute  input  result_packet_t [E_WIDTH-1:0]  per-requester result; the .valid field is the request.
REQ-009 stall  output  [E_WIDTH-1:0]  combinational; 0 = requester granted this cycle, 1 = not granted.
REQ-010 complete  output  complete_packet_t [C_WIDTH-1:0]  registered completion slots.
REQ-011 reg_file_write_tag  output  phy_reg_tag_t [C_WIDTH-1:0]  registered register-file write tags.
REQ-012 reg_file_write_value  output  xlen_t [C_WIDTH-1:0]  registered register-file write data.

Function
REQ-013 State: rr_ptr (PTR_LEN bits) plus output register bank holding C_WIDTH slots of {valid, phy_dest_reg, rob_index, result}.
REQ-014 Grant scan, when flush=0 and hold=0: visit indices rr_ptr, rr_ptr+1, ... mod E_WIDTH once each; grant the first C_WIDTH with execute[i].valid=1.
REQ-015 Slot assignment: the k-th granted requester in scan order goes to slot k; unused slots have valid=0.
REQ-016 stall[i]=0 iff requester i is granted this cycle; otherwise stall[i]=1, including when execute[i].valid=0.
REQ-017 Grant latency: a requester granted in cycle N appears on complete / reg_file_write_* in cycle N+1 (one register stage).
REQ-018 complete[k] gets valid=1, phy_dest_reg and rob_index of the granted packet; reg_file_write_tag[k]=phy_dest_reg; reg_file_write_value[k]=result.
REQ-019 Any slot not written in the previous cycle drives all-zero complete, tag and value.
REQ-020 Pointer update: if at least one grant occurs, rr_ptr_next = (index of last granted requester + 1) mod E_WIDTH; if no grant occurs, rr_ptr is unchanged.
REQ-021 hold=1 and flush=0: no grants, all stall=1, output register bank and rr_ptr retain their values.
REQ-022 flush=1: no grants, all stall=1, output register bank cleared to zero next cycle, rr_ptr set to 0; flush overrides hold.
REQ-023 Fewer than C_WIDTH valid requesters: all valid requesters are granted in the same cycle.
REQ-024 Wrap-around: the scan wraps from E_WIDTH-1 to 0 within one cycle, and each requester is granted at most once per cycle.
REQ-025 Fairness: under continuous requests from all E_WIDTH requesters, every requester is granted within ceil(E_WIDTH/C_WIDTH) consecutive non-hold cycles.
REQ-026 Requesters hold execute[i] stable while stall[i]=1; the block holds no copy of an ungranted request.

Reset
REQ-027 reset=1 on posedge: rr_ptr=0, all output slots zero (complete, tag, value all 0); reset takes priority over flush and hold.
REQ-028 During a cycle with reset=1, stall is all ones and no grant is recorded.
REQ-029 Reset mid-operation discards registered completions; no completion from before reset appears afterward.

Verification (C_WIDTH=2, E_WIDTH=8)
REQ-030 After reset, all 8 requesters valid, rr_ptr=0 -> stall=8'b1111_1100; next cycle complete[0]/[1] show requesters 0/1; rr_ptr=2.
REQ-031 rr_ptr=6, requesters 7 and 1 valid -> slot0=req7, slot1=req1, stall=8'b0111_1101, rr_ptr becomes 2.
REQ-032 Only requester 3 valid (phy_dest_reg=5, result=32'hDEAD_BEEF) -> next cycle complete[0].valid=1, reg_file_write_tag[0]=5, reg_file_write_value[0]=32'hDEAD_BEEF; slot1 all zero.
REQ-033 Slots hold req0/req1, then hold=1 for 3 cycles with all requesters valid -> stall all ones, outputs and rr_ptr unchanged for those 3 cycles.
REQ-034 flush=1 with hold=1 and all requesters valid -> stall all ones; next cycle all outputs zero and rr_ptr=0.
REQ-035 All 8 requesters continuously valid for 4 cycles -> each requester granted exactly once, in order 0-1, 2-3, 4-5, 6-7.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: shared types and the completion-bus interface between execute units and the CDB arbiter
// Ports (interface signals): flush, hold, execute (requests); stall, complete,
// reg_file_write_tag, reg_file_write_value (arbiter responses).
package cdb_pkg;
    localparam int WAY = 2;
    localparam int NUM_FU_TYPE = 4;
    localparam int XLEN = 32;
    localparam int PHY_REG_LEN = 6;
    localparam int ROB_IDX_LEN = 5;
    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [PHY_REG_LEN-1:0] phy_reg_tag_t;
    typedef logic [ROB_IDX_LEN-1:0] rob_index_t;
    typedef struct packed {
        logic         valid;
        phy_reg_tag_t phy_dest_reg;
        rob_index_t   rob_index;
        xlen_t        result;
    } result_packet_t;
    typedef struct packed {
        logic         valid;
        phy_reg_tag_t phy_dest_reg;
        rob_index_t   rob_index;
    } complete_packet_t;
endpackage

interface cdb_arbiter_if #(
    parameter int C_WIDTH = cdb_pkg::WAY,
    parameter int E_WIDTH = cdb_pkg::NUM_FU_TYPE * cdb_pkg::WAY
);
    logic                                       flush;
    logic                                       hold;
    cdb_pkg::result_packet_t   [E_WIDTH-1:0]    execute;
    logic                      [E_WIDTH-1:0]    stall;
    cdb_pkg::complete_packet_t [C_WIDTH-1:0]    complete;
    cdb_pkg::phy_reg_tag_t     [C_WIDTH-1:0]    reg_file_write_tag;
    cdb_pkg::xlen_t            [C_WIDTH-1:0]    reg_file_write_value;

    modport master (
        output flush, hold, execute,
        input  stall, complete, reg_file_write_tag, reg_file_write_value
    );
    modport slave (
        input  flush, hold, execute,
        output stall, complete, reg_file_write_tag, reg_file_write_value
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter granting up to C_WIDTH execute results per cycle onto the completion bus
// Ports: clock, reset (synchronous, active-high);
//        bus (slave): flush, hold, execute in; stall (combinational, 0 = granted) out;
//        complete, reg_file_write_tag, reg_file_write_value out, registered one cycle after the grant.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int C_WIDTH = WAY,
    parameter int E_WIDTH = NUM_FU_TYPE * WAY
) (
    input logic          clock,
    input logic          reset,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_LEN = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

    logic [PTR_LEN-1:0] rr_ptr, ptr_nxt, idx, last;
    logic [E_WIDTH-1:0] grant;
    logic [PTR_LEN-1:0] sel [C_WIDTH];
    logic [C_WIDTH-1:0] sel_vld;
    logic               active;
    int                 cnt;

    assign active    = !reset && !bus.flush && !bus.hold;
    assign bus.stall = ~grant;
    assign ptr_nxt   = (last == PTR_LEN'(E_WIDTH - 1)) ? '0 : last + 1'b1;

    // Scan once around the ring starting at rr_ptr; the k-th hit lands in slot k.
    always_comb begin
        grant   = '0;
        sel     = '{default: '0};
        sel_vld = '0;
        cnt     = 0;
        idx     = rr_ptr;
        last    = rr_ptr;
        for (int j = 0; j < E_WIDTH; j++) begin
            idx = PTR_LEN'((int'(rr_ptr) + j) % E_WIDTH);
            if (active && bus.execute[idx].valid && cnt < C_WIDTH) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < C_WIDTH; k++) begin
                    if (cnt == k) begin
                        sel[k]     = idx;
                        sel_vld[k] = 1'b1;
                    end
                end
                cnt  = cnt + 1;
                last = idx;
            end
        end
    end

    // Hold freezes both the pointer and the output bank; flush and reset clear them.
    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            rr_ptr                   <= '0;
            bus.complete             <= '0;
            bus.reg_file_write_tag   <= '0;
            bus.reg_file_write_value <= '0;
        end else if (!bus.hold) begin
            rr_ptr <= |grant ? ptr_nxt : rr_ptr;
            for (int k = 0; k < C_WIDTH; k++) begin
                bus.complete[k]             <= sel_vld[k] ? complete_packet_t'{1'b1,
                                               bus.execute[sel[k]].phy_dest_reg,
                                               bus.execute[sel[k]].rob_index} : '0;
                bus.reg_file_write_tag[k]   <= sel_vld[k] ? bus.execute[sel[k]].phy_dest_reg : '0;
                bus.reg_file_write_value[k] <= sel_vld[k] ? bus.execute[sel[k]].result : '0;
            end
        end
    end
endmodule
